// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared byte constants, FSM states and frame-length helper for uart_point_framer
// Contents: header/trailer byte constants, state_e (IDLE, LOAD, SEND, WAIT, FIN), frame_len().
package uart_frame_pkg;
  localparam logic [7:0] HDR0_DEF = 8'h53;
  localparam logic [7:0] HDR1_DEF = 8'h54;
  localparam logic [7:0] END_E = 8'h45;
  localparam logic [7:0] END_N = 8'h4E;
  localparam logic [7:0] END_D = 8'h44;
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, FIN} state_e;
  function automatic int frame_len(input int num_points, input int coord_bytes, input bit checksum);
    return 5 + 2 * num_points * coord_bytes + (checksum ? 1 : 0);
  endfunction
endpackage

// File: rtl/frame_byte_mux.sv
// frame_byte_mux: selects frame byte idx_i from the coordinate snapshot and the fixed header/trailer
// Ports: points_h_i/points_v_i snapshot (point k at [k*W +: W], W = COORD_BYTES*8);
//   idx_i byte position in the frame; byte_o selected byte (combinational).
// Define UART_FRAMER_CHECKSUM_EN to insert a mod-256 payload sum between the last V byte and "END".
module frame_byte_mux
  import uart_frame_pkg::*;
#(
  parameter int NUM_POINTS = 8,
  parameter int COORD_BYTES = 2,
  parameter int CW = 6,
  parameter logic [7:0] HDR0 = HDR0_DEF,
  parameter logic [7:0] HDR1 = HDR1_DEF
) (
  input  logic [NUM_POINTS*COORD_BYTES*8-1:0] points_h_i,
  input  logic [NUM_POINTS*COORD_BYTES*8-1:0] points_v_i,
  input  logic [CW-1:0]                       idx_i,
  output logic [7:0]                          byte_o
);
  localparam int W = COORD_BYTES * 8;
  localparam int PB = 2 * NUM_POINTS * COORD_BYTES;
  localparam int PIW = $clog2(PB);
  localparam logic [CW-1:0] PL = CW'(PB);
`ifdef UART_FRAMER_CHECKSUM_EN
  localparam logic [CW-1:0] TL = CW'(PB + 1);
`else
  localparam logic [CW-1:0] TL = CW'(PB);
`endif
  logic [7:0] payload [PB];
  logic [CW-1:0] off, tail;
  // Payload in transmit order: per point, H then V, each most significant byte first.
  for (genvar k = 0; k < NUM_POINTS; k++) begin : g_pt
    for (genvar b = 0; b < COORD_BYTES; b++) begin : g_by
      assign payload[2*COORD_BYTES*k + b] = points_h_i[k*W + (COORD_BYTES-1-b)*8 +: 8];
      assign payload[2*COORD_BYTES*k + COORD_BYTES + b] = points_v_i[k*W + (COORD_BYTES-1-b)*8 +: 8];
    end
  end
  // off wraps for the two header positions, so it only lands inside the payload range for payload bytes.
  assign off = idx_i - CW'(2);
  assign tail = off - TL;
`ifdef UART_FRAMER_CHECKSUM_EN
  logic [7:0] sum;
  always_comb begin
    sum = 8'h00;
    for (int j = 0; j < PB; j++) sum = sum + payload[j];
  end
  always_comb
    byte_o = idx_i == '0 ? HDR0 : idx_i == CW'(1) ? HDR1 : off < PL ? payload[off[PIW-1:0]] :
             off == PL ? sum : tail == '0 ? END_E : tail == CW'(1) ? END_N : END_D;
`else
  always_comb
    byte_o = idx_i == '0 ? HDR0 : idx_i == CW'(1) ? HDR1 : off < PL ? payload[off[PIW-1:0]] :
             tail == '0 ? END_E : tail == CW'(1) ? END_N : END_D;
`endif
endmodule

// File: rtl/uart_point_framer.sv
// uart_point_framer: serialises tracked marker coordinates into a framed byte stream for uart_tx
// Ports: clk_i clock; rst_ni async active-low reset; start_i frame request (level, sampled in IDLE);
//   points_h_i/points_v_i packed coordinates, point k at [k*W +: W]; tx_done_i byte-sent pulse;
//   tx_dv_o byte strobe with tx_byte_o; busy_o LOAD..WAIT; frame_done_o one-cycle end-of-frame pulse.
// Define UART_FRAMER_CHECKSUM_EN to add a mod-256 payload checksum byte before "END".
module uart_point_framer
  import uart_frame_pkg::*;
#(
  parameter int NUM_POINTS = 8,
  parameter int COORD_BYTES = 2,
  parameter int CONTINUOUS = 1,
  parameter logic [7:0] HDR0 = HDR0_DEF,
  parameter logic [7:0] HDR1 = HDR1_DEF
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                start_i,
  input  logic [NUM_POINTS*COORD_BYTES*8-1:0] points_h_i,
  input  logic [NUM_POINTS*COORD_BYTES*8-1:0] points_v_i,
  input  logic                                tx_done_i,
  output logic                                tx_dv_o,
  output logic [7:0]                          tx_byte_o,
  output logic                                busy_o,
  output logic                                frame_done_o
);
`ifdef UART_FRAMER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif
  localparam int FRAME_LEN = frame_len(NUM_POINTS, COORD_BYTES, CK_EN);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int PW = NUM_POINTS * COORD_BYTES * 8;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  state_e state_q, state_d;
  logic [PW-1:0] h_q, v_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] byte_q, mux_byte;
  logic done_q, armed_q, armed_d;
  frame_byte_mux #(
    .NUM_POINTS(NUM_POINTS),
    .COORD_BYTES(COORD_BYTES),
    .CW(CW),
    .HDR0(HDR0),
    .HDR1(HDR1)
  ) u_mux (
    .points_h_i(h_q),
    .points_v_i(v_q),
    .idx_i(cnt_q),
    .byte_o(mux_byte)
  );
  // done_q registers TX_DONE only while waiting, so pulses in other states are dropped and the
  // next byte goes out two cycles after the accepted TX_DONE.
  // armed_q marks that a frame has started since reset; continuous mode needs it to self-restart.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      byte_q <= 8'h00;
      done_q <= 1'b0;
      armed_q <= 1'b0;
      h_q <= '0;
      v_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      armed_q <= armed_d;
      done_q <= tx_done_i && state_q == WAIT;
      if (state_q == LOAD) begin
        h_q <= points_h_i;
        v_q <= points_v_i;
      end
      if (state_q == SEND) byte_q <= mux_byte;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    armed_d = armed_q;
    case (state_q)
      IDLE: state_d = start_i || (CONTINUOUS != 0 && armed_q) ? LOAD : IDLE;
      LOAD: begin
        state_d = SEND;
        cnt_d = '0;
        armed_d = 1'b1;
      end
      SEND: state_d = WAIT;
      WAIT: if (done_q) begin
        state_d = cnt_q == LAST ? FIN : SEND;
        cnt_d = cnt_q == LAST ? cnt_q : cnt_q + CW'(1);
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign tx_dv_o = state_q == SEND;
  assign tx_byte_o = tx_dv_o ? mux_byte : byte_q;
  assign busy_o = state_q == LOAD || state_q == SEND || state_q == WAIT;
  assign frame_done_o = state_q == FIN;
endmodule

// File: tb/tb_uart_point_framer.sv
// tb_uart_point_framer: randomized self-checking bench for uart_point_framer against a frame-layout model
module tb_uart_point_framer;
  localparam int NP = 8;
  localparam int CB = 2;
  localparam int PW = NP * CB * 8;
`ifdef UART_FRAMER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  localparam int LEN0 = 5 + 2 * NP * CB + int'(CK);
  localparam int LEN2 = 5 + 4 + int'(CK);
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] start = '0, extra = '0, resp = '0, dv, busy, fd, done;
  logic [7:0] txb [3];
  logic [PW-1:0] ph = '0, pv = '0;
  logic [15:0] ph2 = '0, pv2 = '0;
  int cyc = 0, n_cmp = 0, n_fail = 0;
  int fd_cnt [3], viol [3], cd [3];
  bit outst [3];
  bit spur_send = 1'b0;
  logic [2:0] busy_prev = '0;
  bq_t rxq [3];
  int dvq [3][$];
  int fdq [3][$];
  int riseq [3][$];
  assign done = resp | extra;
  uart_point_framer #(.NUM_POINTS(NP), .COORD_BYTES(CB), .CONTINUOUS(0)) d0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .points_h_i(ph), .points_v_i(pv),
    .tx_done_i(done[0]), .tx_dv_o(dv[0]), .tx_byte_o(txb[0]), .busy_o(busy[0]), .frame_done_o(fd[0]));
  uart_point_framer #(.NUM_POINTS(NP), .COORD_BYTES(CB), .CONTINUOUS(1)) d1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .points_h_i(ph), .points_v_i(pv),
    .tx_done_i(done[1]), .tx_dv_o(dv[1]), .tx_byte_o(txb[1]), .busy_o(busy[1]), .frame_done_o(fd[1]));
  uart_point_framer #(.NUM_POINTS(2), .COORD_BYTES(1), .CONTINUOUS(0)) d2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start[2]), .points_h_i(ph2), .points_v_i(pv2),
    .tx_done_i(done[2]), .tx_dv_o(dv[2]), .tx_byte_o(txb[2]), .busy_o(busy[2]), .frame_done_o(fd[2]));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Monitor and UART stand-in: log each byte strobe, answer it with TX_DONE five cycles later.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        cd[i] = 0;
        resp[i] = 1'b0;
        outst[i] = 1'b0;
        busy_prev[i] = 1'b0;
      end else begin
        if (done[i]) outst[i] = 1'b0;
        if (dv[i]) begin
          if (outst[i]) viol[i]++;
          outst[i] = 1'b1;
          rxq[i].push_back(txb[i]);
          dvq[i].push_back(cyc);
        end
        if (fd[i]) begin
          fd_cnt[i]++;
          fdq[i].push_back(cyc);
        end
        if (busy[i] && !busy_prev[i]) riseq[i].push_back(cyc);
        busy_prev[i] = busy[i];
        resp[i] = 1'b0;
        if (cd[i] > 0) begin
          cd[i]--;
          if (cd[i] == 0) resp[i] = 1'b1;
        end
        if (dv[i]) begin
          cd[i] = 5;
          if (spur_send) resp[i] = 1'b1;
        end
      end
    end
  end
  function automatic bq_t build(input logic [255:0] h, input logic [255:0] v, input int np, input int cb);
    bq_t f;
    logic [255:0] t;
    logic [7:0] s;
    s = 8'h00;
    f = {8'h53, 8'h54};
    for (int k = 0; k < np; k++)
      for (int a = 0; a < 2; a++)
        for (int b = cb - 1; b >= 0; b--) begin
          t = (a == 0 ? h : v) >> (8 * (k * cb + b));
          f.push_back(t[7:0]);
          s = s + t[7:0];
        end
    if (CK) f.push_back(s);
    f.push_back(8'h45);
    f.push_back(8'h4E);
    f.push_back(8'h44);
    return f;
  endfunction
  function automatic int first_diff(input bq_t a, input bq_t b);
    if (a.size() != b.size()) return -2;
    foreach (a[j]) if (a[j] !== b[j]) return j;
    return -1;
  endfunction
  task automatic clr();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      rxq[i] = {};
      dvq[i] = {};
      fdq[i] = {};
      riseq[i] = {};
      fd_cnt[i] = 0;
      viol[i] = 0;
    end
  endtask
  task automatic rand_pts();
    for (int w = 0; w < PW / 32; w++) begin
      ph[w*32 +: 32] = $urandom();
      pv[w*32 +: 32] = $urandom();
    end
  endtask
  task automatic pulse_start(input int i, output int n);
    @(negedge clk);
    start[i] = 1'b1;
    n = cyc;
    @(negedge clk);
    start[i] = 1'b0;
  endtask
  task automatic wait_fd(input int i, input int n, output bit ok);
    int b;
    b = 0;
    while (fd_cnt[i] < n && b < 3000) begin
      @(negedge clk);
      b++;
    end
    ok = fd_cnt[i] >= n;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({dv[i], txb[i], busy[i], fd[i]} !== 11'h0) begin
        n_fail++;
        $display("FAIL reset_state%0d: got dv=%b byte=%h busy=%b fd=%b, want all 0", i, dv[i], txb[i], busy[i], fd[i]);
      end
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (rxq[1].size() != 0 || busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_waits_start: got %0d bytes busy=%b, want 0 bytes busy=0", rxq[1].size(), busy[1]);
    end
  endtask
  task automatic test_frame();
    bq_t exp;
    int n, d, g;
    bit ok;
    ph = '0;
    pv = '0;
    ph[15:0] = 16'h0123;
    pv[15:0] = 16'h0456;
    for (int r = 0; r < 4; r++) begin
      if (r > 0) rand_pts();
      exp = build(256'(ph), 256'(pv), NP, CB);
      clr();
      pulse_start(0, n);
      wait_fd(0, 1, ok);
      repeat (10) @(negedge clk);
      n_cmp++;
      d = first_diff(rxq[0], exp);
      if (!ok || d != -1) begin
        n_fail++;
        $display("FAIL frame%0d_bytes: got %0d bytes (diff at %0d, done=%b), want %0d bytes", r, rxq[0].size(), d, ok, exp.size());
      end
      n_cmp++;
      if (fd_cnt[0] != 1 || busy[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL frame%0d_done: got %0d pulses busy=%b, want 1 pulse busy=0", r, fd_cnt[0], busy[0]);
      end
      if (r == 0) begin
        n_cmp++;
        if (dvq[0].size() == 0 || dvq[0][0] != n + 2) begin
          n_fail++;
          $display("FAIL start_latency: got first dv at %0d, want %0d", dvq[0].size() ? dvq[0][0] : -1, n + 2);
        end
        g = -1;
        for (int j = 0; j + 1 < dvq[0].size(); j++) if (g < 0 && dvq[0][j+1] - dvq[0][j] != 7) g = j;
        n_cmp++;
        if (g >= 0) begin
          n_fail++;
          $display("FAIL done_latency: got dv gap %0d after byte %0d, want 7", dvq[0][g+1] - dvq[0][g], g);
        end
        n_cmp++;
        if (viol[0] != 0) begin
          n_fail++;
          $display("FAIL dv_handshake: got %0d double strobes, want 0", viol[0]);
        end
      end
    end
  endtask
  task automatic test_snapshot();
    bq_t exp;
    int n, b;
    bit ok;
    rand_pts();
    exp = build(256'(ph), 256'(pv), NP, CB);
    clr();
    pulse_start(0, n);
    b = 0;
    while (dvq[0].size() == 0 && b < 100) begin
      @(negedge clk);
      b++;
    end
    ph = ~ph;
    pv = ~pv;
    ph[15:0] = 16'hFFFF;
    wait_fd(0, 1, ok);
    n_cmp++;
    if (!ok || first_diff(rxq[0], exp) != -1) begin
      n_fail++;
      $display("FAIL snapshot: got %0d bytes (diff at %0d), want %0d bytes of the LOAD-time points", rxq[0].size(), first_diff(rxq[0], exp), exp.size());
    end
  endtask
  task automatic test_continuous();
    bq_t fa, fb, exp;
    int n, b;
    bit ok;
    rand_pts();
    fa = build(256'(ph), 256'(pv), NP, CB);
    clr();
    pulse_start(1, n);
    b = 0;
    while (dvq[1].size() == 0 && b < 100) begin
      @(negedge clk);
      b++;
    end
    rand_pts();
    fb = build(256'(ph), 256'(pv), NP, CB);
    wait_fd(1, 3, ok);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp = {fa, fb, fb};
    n_cmp++;
    if (!ok || first_diff(rxq[1], exp) != -1) begin
      n_fail++;
      $display("FAIL continuous_bytes: got %0d bytes (diff at %0d), want %0d", rxq[1].size(), first_diff(rxq[1], exp), exp.size());
    end
    n_cmp++;
    if (dvq[1].size() == 0 || dvq[1][0] != n + 2) begin
      n_fail++;
      $display("FAIL continuous_start: got first dv at %0d, want %0d", dvq[1].size() ? dvq[1][0] : -1, n + 2);
    end
    n_cmp++;
    if (riseq[1].size() < 3 || fdq[1].size() < 2 || riseq[1][1] - fdq[1][0] != 2 || riseq[1][2] - fdq[1][1] != 2) begin
      n_fail++;
      $display("FAIL continuous_gap: got %0d loads %0d fins, want LOAD 2 cycles after each FIN", riseq[1].size(), fdq[1].size());
    end
  endtask
  task automatic test_reset_mid();
    bq_t exp;
    int n, b, sz;
    bit ok;
    rand_pts();
    clr();
    pulse_start(0, n);
    b = 0;
    while (dvq[0].size() < 11 && b < 300) begin
      @(negedge clk);
      b++;
    end
    n_cmp++;
    if (dvq[0].size() < 11) begin
      n_fail++;
      $display("FAIL reset_mid_reach: got %0d bytes, want 11 before reset", dvq[0].size());
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dv[0], txb[0], busy[0], fd[0]} !== 11'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got dv=%b byte=%h busy=%b fd=%b, want all 0", dv[0], txb[0], busy[0], fd[0]);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sz = rxq[0].size();
    repeat (40) @(negedge clk);
    n_cmp++;
    if (rxq[0].size() != sz || fd_cnt[0] != 0) begin
      n_fail++;
      $display("FAIL reset_mid_silent: got %0d new bytes %0d fins, want 0 and 0", rxq[0].size() - sz, fd_cnt[0]);
    end
    rand_pts();
    exp = build(256'(ph), 256'(pv), NP, CB);
    clr();
    pulse_start(0, n);
    wait_fd(0, 1, ok);
    n_cmp++;
    if (!ok || first_diff(rxq[0], exp) != -1) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got %0d bytes (diff at %0d), want %0d", rxq[0].size(), first_diff(rxq[0], exp), exp.size());
    end
  endtask
  task automatic test_checksum();
    bq_t exp;
    int n;
    bit ok;
    for (int r = 0; r < 3; r++) begin
      if (r == 0) begin
        ph2 = {8'h20, 8'h10};
        pv2 = {8'h40, 8'h30};
      end else begin
        ph2 = 16'($urandom());
        pv2 = 16'($urandom());
      end
      exp = build(256'(ph2), 256'(pv2), 2, 1);
      clr();
      pulse_start(2, n);
      wait_fd(2, 1, ok);
      n_cmp++;
      if (!ok || rxq[2].size() != LEN2 || first_diff(rxq[2], exp) != -1) begin
        n_fail++;
        $display("FAIL small_frame%0d: got %0d bytes (diff at %0d), want %0d", r, rxq[2].size(), first_diff(rxq[2], exp), LEN2);
      end
    end
  endtask
  task automatic test_spurious();
    bq_t exp;
    bit ok;
    int sz;
    clr();
    @(negedge clk);
    extra[0] = 1'b1;
    repeat (3) @(negedge clk);
    extra[0] = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (rxq[0].size() != 0 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_done_ignored: got %0d bytes busy=%b, want 0 bytes busy=0", rxq[0].size(), busy[0]);
    end
    rand_pts();
    exp = build(256'(ph), 256'(pv), NP, CB);
    spur_send = 1'b1;
    @(negedge clk);
    start[0] = 1'b1;
    wait_fd(0, 1, ok);
    start[0] = 1'b0;
    spur_send = 1'b0;
    sz = rxq[0].size();
    repeat (40) @(negedge clk);
    n_cmp++;
    if (!ok || sz != LEN0 || first_diff(rxq[0], exp) != -1) begin
      n_fail++;
      $display("FAIL spurious_frame: got %0d bytes (diff at %0d), want %0d", sz, first_diff(rxq[0], exp), LEN0);
    end
    n_cmp++;
    if (fd_cnt[0] != 1 || rxq[0].size() != sz) begin
      n_fail++;
      $display("FAIL start_held_ignored: got %0d fins %0d extra bytes, want 1 fin 0 extra", fd_cnt[0], rxq[0].size() - sz);
    end
    n_cmp++;
    if (viol[0] != 0) begin
      n_fail++;
      $display("FAIL spurious_handshake: got %0d double strobes, want 0", viol[0]);
    end
  endtask
  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_frame();
    test_snapshot();
    test_continuous();
    test_reset_mid();
    test_checksum();
    test_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_point_framer.md
Name: uart_point_framer

Overview:
Serialises a parametrised set of tracked marker coordinates into a framed byte stream for the UART transmitter. It drives the UART TX byte interface using a byte-valid / done handshake. All point data is captured atomically when a frame starts, so no frame ever mixes coordinates from two video frames. Sits between the blob/centroid tracker outputs and uart_tx.

Parameters:
NUM_POINTS, 8, number of points per frame (1..32)
COORD_BYTES, 2, bytes per coordinate, big-endian (1..4)
CONTINUOUS, 1, 1 = start the next frame automatically after FRAME_DONE; 0 = wait for START
HDR0, 8'h53, first header byte ("S")
HDR1, 8'h54, second header byte ("T")

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
START  in  1  frame request; level-sampled in IDLE
POINTS_H  in  NUM_POINTS*COORD_BYTES*8  packed horizontal coordinates, point k at slice [k*W +: W], where W = COORD_BYTES*8
POINTS_V  in  NUM_POINTS*COORD_BYTES*8  packed vertical coordinates, same packing
TX_DONE  in  1  one-cycle pulse from uart_tx when the current byte has been sent
TX_DV  out  1  one-cycle pulse; TX_BYTE is valid in the same cycle
TX_BYTE  out  8  byte to transmit
BUSY  out  1  high from LOAD until the end of the frame
FRAME_DONE  out  1  one-cycle pulse after the final byte's TX_DONE

Behaviour:
- Reset (asynchronous, RST_N low): state = IDLE; TX_DV = 0; TX_BYTE = 8'h00; BUSY = 0; FRAME_DONE = 0; byte counter = 0. Assertion mid-frame aborts the frame immediately; no partial continuation after release.
- Frame layout: HDR0, HDR1, then for k = 0..NUM_POINTS-1: H[k] MSB..LSB, V[k] MSB..LSB, then 8'h45 8'h4E 8'h44 ("END").
- FRAME_LEN = 2 + 2*NUM_POINTS*COORD_BYTES + 3 (+1 with checksum). Default FRAME_LEN = 37.
- Byte counter width = $clog2(FRAME_LEN + 1).
- States:
  - IDLE: if START = 1 or (CONTINUOUS = 1 and not just out of reset), go to LOAD. After reset, the first frame always waits for START, regardless of CONTINUOUS.
  - LOAD (1 cycle): snapshot POINTS_H and POINTS_V into internal registers; counter = 0; BUSY = 1. Go to SEND.
  - SEND (1 cycle): TX_BYTE = byte[counter] from the snapshot; TX_DV = 1. Go to WAIT.
  - WAIT: TX_DV = 0; TX_BYTE holds its value. On TX_DONE: if counter = FRAME_LEN-1, go to FIN; otherwise counter+1 and go to SEND.
  - FIN (1 cycle): FRAME_DONE = 1; BUSY = 0. Go to IDLE.
- Latency:
  - START high in IDLE at cycle n: LOAD at n+1, first TX_DV at n+2.
  - TX_DONE at cycle m: next TX_DV at m+2.
- TX_DONE outside WAIT is ignored. START during BUSY is ignored (not queued).
- Input changes after LOAD do not affect the frame in progress.
- TX_DV is never asserted twice without an intervening TX_DONE.

Optional Feature:
Macro: UART_FRAMER_CHECKSUM_EN.
- Defined: one extra byte is inserted between the last V byte and "E". Its value is the 8-bit modulo-256 sum of all payload coordinate bytes (headers excluded), accumulated combinationally from the snapshot. FRAME_LEN grows by 1.
- Undefined: no checksum byte and no accumulator logic.

Decomposition:
- Package uart_frame_pkg:
  - HDR/END byte constants
  - state enum (IDLE, LOAD, SEND, WAIT, FIN)
  - function frame_len(NUM_POINTS, COORD_BYTES, checksum)
- One sub-module, frame_byte_mux: combinational selection of byte[counter] from the snapshot registers and constants, so the FSM stays separate from the layout logic.

Test Plan:
1. Defaults, CONTINUOUS=0; POINTS_H[0]=16'h0123, POINTS_V[0]=16'h0456, others 0; pulse START; bench answers each TX_DV with TX_DONE 5 cycles later -> 37 bytes: 53 54 01 23 04 56, then 28×00, then 45 4E 44; single FRAME_DONE pulse; BUSY low afterwards.
2. Snapshot: change POINTS_H[0] to 16'hFFFF one cycle after LOAD -> frame still carries 01 23.
3. CONTINUOUS=1, single START -> back-to-back frames with no START needed, exactly 1 IDLE cycle between FIN and the next LOAD.
4. Reset mid-frame: assert RST_N low during byte 10's WAIT -> all outputs at reset values immediately; after release, no TX_DV until START.
5. NUM_POINTS=2, COORD_BYTES=1, H={8'h10,8'h20}, V={8'h30,8'h40}, with UART_FRAMER_CHECKSUM_EN defined -> bytes 53 54 10 30 20 40 A0 45 4E 44 (10 bytes).
6. Spurious TX_DONE pulses in IDLE and SEND, plus START held high while BUSY -> no skipped or extra bytes; byte count per frame equals FRAME_LEN.
